// File: rtl/gc_wptr_ctrl.sv
// Write-side pointer controller for a Gray-coded CDC FIFO: handshake, binary/Gray
// write pointer, read-pointer synchroniser, full/level derivation and flush drain.
//
// state | meaning
// RUN   | accepting writes whenever not full
// DRAIN | writes stalled until the synchronised read pointer catches up
module gc_wptr_ctrl #(
    parameter int AW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          wr_en,
    output logic [AW-2:0] wr_addr,
    output logic [AW-1:0] wptr_gc,
    input  logic [AW-1:0] rptr_gc_async,
    output logic          full,
    output logic [AW-1:0] level,
    output logic          flush_busy
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] wbin;
    logic [AW-1:0] wbin_nxt;
    logic [AW-1:0] rsync;
    logic [AW-1:0] rbin_sync;
    logic [AW-1:0] sync_q [SYNC];
    logic          accept;

    assign rsync = sync_q[SYNC-1];

    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < AW; i++) begin
            rbin_sync[i] = ^(rsync >> i);
        end
    end

    assign full       = (wptr_gc == {~rsync[AW-1:AW-2], rsync[AW-3:0]});
    assign level      = wbin - rbin_sync;
    assign wr_ready   = (state == RUN) && !full;
    assign accept     = wr_valid && wr_ready;
    // Gated by reset so no strobe reaches the RAM while the block is held in reset.
    assign wr_en      = accept && rstn;
    assign wr_addr    = wbin[AW-2:0];
    assign flush_busy = (state == DRAIN);
    assign wbin_nxt   = wbin + AW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gc_async;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbin    <= '0;
            wptr_gc <= '0;
            state   <= RUN;
        end else begin
            if (accept) begin
                wbin    <= wbin_nxt;
                wptr_gc <= wbin_nxt ^ (wbin_nxt >> 1);
            end
            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if (rsync == wptr_gc) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
